// File: rtl/sos_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sos_sched_pkg
//  Description : Shared types and the round-robin pick function for the
//                multi-channel SOS IIR engine scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sos_sched_pkg;

    // Widest channel count the generic pick function can search
    localparam int RR_MAX_CH = 32;
    localparam int RR_IDX_W  = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RETURN = 3'd3,
        ABORT  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request strictly after ptr (wrapping modulo nch) wins
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_CH-1:0] pending,
        input logic [RR_IDX_W-1:0]  ptr,
        input int                   nch
    );
        rr_pick_t r;
        int       j;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = 1; i <= RR_MAX_CH; i++) begin
            j = (int'(ptr) + i) % nch;
            if (!r.valid && (i <= nch) && pending[RR_IDX_W'(j)]) begin
                r.valid = 1'b1;
                r.idx   = RR_IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sos_iir_ch_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : NCH-wide round-robin arbiter: combinational pick plus the
//                last-granted pointer register. Pointer resets to NCH-1 so
//                channel 0 wins first.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sos_sched_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [NCH-1:0] req_i,
    input  logic           advance_i,
    output logic           gnt_valid_o,
    output logic [CHW-1:0] gnt_idx_o
);

    logic [RR_IDX_W-1:0] r_ptr;
    rr_pick_t            w_pick;

    // Search for the next requester after the last granted channel
    always_comb begin
        w_pick = rr_pick(RR_MAX_CH'(req_i), r_ptr, NCH);
    end

    assign gnt_valid_o = w_pick.valid;
    assign gnt_idx_o   = w_pick.idx[CHW-1:0];

    // Pointer follows the granted channel only when the grant is taken
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= RR_IDX_W'(NCH - 1);
        end else if (advance_i && w_pick.valid) begin
            r_ptr <= w_pick.idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sos_iir_ch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sos_iir_ch_scheduler
//  Description : Time-shares one looped SOS IIR engine between NCH channels.
//                Captures one sample per channel, grants round-robin, drives
//                the engine state-bank select, routes the result back to its
//                owner and aborts a hung engine after TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sos_iir_ch_scheduler
    import sos_sched_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int DW      = 16,
    parameter  int TIMEOUT = 64,
    localparam int CHW     = $clog2(NCH)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NCH-1:0]          ch_valid_i,
    input  logic [NCH-1:0][DW-1:0]  ch_data_i,
    output logic [DW-1:0]           ch_data_o,
    output logic [NCH-1:0]          ch_valid_o,
    output logic [NCH-1:0]          overrun_o,
    output logic                    timeout_o,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic                    eng_start_o,
    output logic [DW-1:0]           eng_data_o,
    output logic [CHW-1:0]          eng_ctx_o,
    output logic                    eng_srst_o,
    input  logic [DW-1:0]           eng_data_i,
    input  logic                    eng_valid_i
);

    localparam int               c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    sched_state_t                r_state;
    sched_state_t                w_state_nxt;
    logic [NCH-1:0][DW-1:0]      r_hold;
    logic [NCH-1:0]              r_pending;
    logic [NCH-1:0]              w_issue_clr;
    logic [CHW-1:0]              r_gnt;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        w_pick_valid;
    logic [CHW-1:0]              w_pick_idx;
    logic                        w_grant;
    logic [DW-1:0]               w_issue_data;

    rr_arbiter #(
        .NCH        (NCH)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (r_pending),
        .advance_i  (w_grant),
        .gnt_valid_o(w_pick_valid),
        .gnt_idx_o  (w_pick_idx)
    );

    assign w_grant   = (r_state == IDLE) && w_pick_valid;
    assign eng_ctx_o = r_gnt;

    // A strobe landing in the grant cycle is forwarded so the engine gets the newest sample
    assign w_issue_data = ch_valid_i[w_pick_idx] ? ch_data_i[w_pick_idx] : r_hold[w_pick_idx];

    // The granted channel's pending bit is consumed during ISSUE
    always_comb begin
        w_issue_clr = '0;
        for (int k = 0; k < NCH; k++) begin
            w_issue_clr[k] = (r_state == ISSUE) && (r_gnt == CHW'(k));
        end
    end

    // Per-channel sample capture, pending flags and sticky overrun flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hold    <= '0;
            r_pending <= '0;
            overrun_o <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ch_valid_i[k]) begin
                    r_hold[k]    <= ch_data_i[k];
                    r_pending[k] <= 1'b1;
                end else if (w_issue_clr[k]) begin
                    r_pending[k] <= 1'b0;
                end
                if (ch_valid_i[k] && r_pending[k] && !w_issue_clr[k]) begin
                    overrun_o[k] <= 1'b1;
                end else if (clear_i) begin
                    overrun_o[k] <= 1'b0;
                end
            end
        end
    end

    // Next-state logic for the issue/wait/return sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT: begin
                if (eng_valid_i) begin
                    w_state_nxt = RETURN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ABORT;
                end
            end
            RETURN:  w_state_nxt = IDLE;
            ABORT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered outputs derived from the upcoming state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_cnt       <= '0;
            ch_data_o   <= '0;
            ch_valid_o  <= '0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b0;
            eng_start_o <= 1'b0;
            eng_data_o  <= '0;
            eng_srst_o  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            busy_o      <= (w_state_nxt != IDLE);
            eng_start_o <= (w_state_nxt == ISSUE);
            eng_srst_o  <= (w_state_nxt == ABORT);
            ch_valid_o  <= '0;
            if (w_grant) begin
                r_gnt      <= w_pick_idx;
                eng_data_o <= w_issue_data;
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == WAIT) && eng_valid_i) begin
                ch_data_o  <= eng_data_i;
                ch_valid_o <= NCH'(1) << r_gnt;
            end
            if (w_state_nxt == ABORT) begin
                timeout_o <= 1'b1;
            end else if (clear_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sos_iir_ch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sos_iir_ch_scheduler
//  Description : Scoreboard bench for sos_iir_ch_scheduler with a behavioural
//                echo engine of fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sos_iir_ch_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int LAT = 9;

    typedef struct packed { logic [1:0] ctx; logic [DW-1:0] data; } issue_t;
    typedef struct packed { logic [NCH-1:0] oh; logic [DW-1:0] data; } out_t;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b1;
    logic [NCH-1:0]         ch_valid_i = '0;
    logic [NCH-1:0][DW-1:0] ch_data_i = '0;
    logic [DW-1:0]          ch_data_o;
    logic [NCH-1:0]         ch_valid_o;
    logic [NCH-1:0]         overrun_o;
    logic                   timeout_o;
    logic                   clear_i = 1'b0;
    logic                   busy_o;
    logic                   eng_start_o;
    logic [DW-1:0]          eng_data_o;
    logic [1:0]             eng_ctx_o;
    logic                   eng_srst_o;
    logic [DW-1:0]          eng_data_i = '0;
    logic                   eng_valid_i = 1'b0;

    int     n_checks = 0;
    int     n_errors = 0;
    int     srst_pulses = 0;
    int     eng_gen = 0;
    logic   eng_mute = 1'b0;
    issue_t q_issue[$];
    out_t   q_out[$];

    sos_iir_ch_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i),
        .ch_data_o(ch_data_o), .ch_valid_o(ch_valid_o), .overrun_o(overrun_o),
        .timeout_o(timeout_o), .clear_i(clear_i), .busy_o(busy_o),
        .eng_start_o(eng_start_o), .eng_data_o(eng_data_o), .eng_ctx_o(eng_ctx_o),
        .eng_srst_o(eng_srst_o), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [NCH-1:0] mask, input logic [NCH-1:0][DW-1:0] data);
        ch_valid_i = mask;
        ch_data_i  = data;
        tick(1);
        ch_valid_i = '0;
    endtask

    task automatic strobe1(input int ch, input logic [DW-1:0] d);
        logic [NCH-1:0]         m;
        logic [NCH-1:0][DW-1:0] v;
        m = '0;
        v = '0;
        m[ch] = 1'b1;
        v[ch] = d;
        strobe(m, v);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        eng_gen++;
        #2;
        check("rst_ch_data", 32'(ch_data_o), 32'h0);
        check("rst_eng_data", 32'(eng_data_o), 32'h0);
        check("rst_ctrl", 32'({ch_valid_o, overrun_o, timeout_o, busy_o, eng_start_o, eng_ctx_o, eng_srst_o}), 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        tick(1);
    endtask

    task automatic wait_start(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (eng_start_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail(name);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (q_issue.size() == 0 && q_out.size() == 0 && !busy_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) flag_fail(name);
        tick(1);
    endtask

    // Monitor: compares every engine start and every channel result against the queues
    initial begin
        issue_t ei;
        out_t   eo;
        forever begin
            @(negedge clk_i);
            if (eng_srst_o) srst_pulses++;
            if (eng_start_o) begin
                if (q_issue.size() == 0) begin
                    flag_fail("unexpected_eng_start");
                end else begin
                    ei = q_issue.pop_front();
                    check("issue_ctx", 32'(eng_ctx_o), 32'(ei.ctx));
                    check("issue_data", 32'(eng_data_o), 32'(ei.data));
                end
            end
            if (ch_valid_o != '0) begin
                if (q_out.size() == 0) begin
                    flag_fail("unexpected_ch_valid");
                end else begin
                    eo = q_out.pop_front();
                    check("out_owner", 32'(ch_valid_o), 32'(eo.oh));
                    check("out_data", 32'(ch_data_o), 32'(eo.data));
                end
            end
        end
    end

    // Echo engine: returns the issued sample LAT cycles after start
    initial begin
        logic [DW-1:0] d;
        int            g;
        forever begin
            @(negedge clk_i);
            if (eng_start_o && !eng_mute && rst_n_i) begin
                d = eng_data_o;
                g = eng_gen;
                repeat (LAT) @(posedge clk_i);
                #1;
                if (g == eng_gen) begin
                    eng_valid_i = 1'b1;
                    eng_data_i  = d;
                    @(posedge clk_i);
                    #1;
                    eng_valid_i = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        logic                   seen;
        int                     n_abort;
        logic [NCH-1:0][DW-1:0] v;

        #1;
        do_reset();

        // Single channel, latency and routing
        q_issue.push_back(issue_t'{2'd0, 16'h1000});
        q_out.push_back(out_t'{4'b0001, 16'h1000});
        ch_data_i[0] = 16'h1000;
        ch_valid_i   = 4'b0001;
        tick(1);
        ch_valid_i = '0;
        check("t1_no_start_after_1", 32'(eng_start_o), 32'h0);
        tick(1);
        check("t1_start_after_2", 32'(eng_start_o), 32'h1);
        check("t1_ctx", 32'(eng_ctx_o), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (eng_valid_i) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("t1_engine_valid");
        @(posedge clk_i);
        #1;
        check("t1_ch_valid", 32'(ch_valid_o), 32'h1);
        check("t1_ch_data", 32'(ch_data_o), 32'h1000);
        tick(1);
        check("t1_valid_drops", 32'(ch_valid_o), 32'h0);
        check("t1_data_holds", 32'(ch_data_o), 32'h1000);
        wait_idle("t1_idle");

        // Simultaneous strobes from reset: served 0,1,2,3
        do_reset();
        for (int k = 0; k < NCH; k++) begin
            q_issue.push_back(issue_t'{2'(k), 16'(k + 1)});
            q_out.push_back(out_t'{4'(1 << k), 16'(k + 1)});
        end
        strobe(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
        wait_idle("t2_idle");
        check("t2_no_overrun", 32'(overrun_o), 32'h0);

        // Fairness: ch2 gets in between two ch0 samples
        q_issue.push_back(issue_t'{2'd0, 16'h0010});
        q_issue.push_back(issue_t'{2'd2, 16'h0020});
        q_issue.push_back(issue_t'{2'd0, 16'h0011});
        q_issue.push_back(issue_t'{2'd0, 16'h0012});
        q_out.push_back(out_t'{4'b0001, 16'h0010});
        q_out.push_back(out_t'{4'b0100, 16'h0020});
        q_out.push_back(out_t'{4'b0001, 16'h0011});
        q_out.push_back(out_t'{4'b0001, 16'h0012});
        strobe1(0, 16'h0010);
        wait_start("t3_start_a");
        tick(3);
        v = '0;
        v[0] = 16'h0011;
        v[2] = 16'h0020;
        strobe(4'b0101, v);
        wait_start("t3_start_b");
        wait_start("t3_start_c");
        tick(3);
        strobe1(0, 16'h0012);
        wait_idle("t3_idle");
        check("t3_no_overrun", 32'(overrun_o), 32'h0);

        // Overrun: newest sample wins
        q_issue.push_back(issue_t'{2'd1, 16'h0007});
        q_out.push_back(out_t'{4'b0010, 16'h0007});
        strobe1(1, 16'h0005);
        strobe1(1, 16'h0007);
        wait_idle("t4_idle");
        check("t4_overrun_set", 32'(overrun_o), 32'h2);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check("t4_overrun_clear", 32'(overrun_o), 32'h0);

        // Timeout on ch3, then ch1 served normally
        eng_mute = 1'b1;
        q_issue.push_back(issue_t'{2'd3, 16'h0033});
        q_issue.push_back(issue_t'{2'd1, 16'h0044});
        q_out.push_back(out_t'{4'b0010, 16'h0044});
        v = '0;
        v[1] = 16'h0044;
        v[3] = 16'h0033;
        strobe(4'b1010, v);
        wait_start("t5_start");
        n_abort = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if (eng_srst_o) begin
                n_abort = i;
                break;
            end
        end
        eng_mute = 1'b0;
        check("t5_abort_cycle", 32'(n_abort), 32'd65);
        check("t5_timeout_flag", 32'(timeout_o), 32'h1);
        @(negedge clk_i);
        check("t5_srst_pulse_len", 32'(eng_srst_o), 32'h0);
        wait_idle("t5_idle");
        check("t5_timeout_sticky", 32'(timeout_o), 32'h1);
        check("t5_srst_count", 32'(srst_pulses), 32'd1);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check("t5_timeout_clear", 32'(timeout_o), 32'h0);

        // Asynchronous reset in the middle of WAIT
        q_issue.push_back(issue_t'{2'd2, 16'h0055});
        strobe1(2, 16'h0055);
        wait_start("t6_start");
        tick(3);
        strobe1(1, 16'h0077);
        #2;
        do_reset();
        q_issue.push_back(issue_t'{2'd0, 16'h0066});
        q_out.push_back(out_t'{4'b0001, 16'h0066});
        strobe1(0, 16'h0066);
        wait_idle("t6_idle");

        check("end_issue_queue", 32'(q_issue.size()), 32'd0);
        check("end_out_queue", 32'(q_out.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
